// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with skid buffer.
// in_ready, out_valid and occupancy come straight from flops, so in_ready has no path from out_ready.
module pipe_skid_reg #(
  parameter int W          = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  // state | meaning
  // EMPTY | nothing held, out_valid=0
  // ONE   | main holds the head entry
  // FULL  | main holds the head, skid holds the next entry; in_ready=0
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [1:0]     occ_q;
  logic           in_xfer;
  logic           out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including the entry offered this cycle.
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_DATA) begin
        main_d = '0;
        skid_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      if (CLEAR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      case (state_d)
        ONE:     occ_q <= 2'd1;
        FULL:    occ_q <= 2'd2;
        default: occ_q <= 2'd0;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then randomized traffic,
// all compared against a FIFO-queue reference of depth two.
module tb_pipe_skid_reg;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  bit           zero_exp = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.W(W), .CLEAR_DATA(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the reference queue, then compare all outputs.
  task automatic step(input bit rst, input bit fl, input bit iv, input logic [W-1:0] d, input bit ordy);
    bit ir, ov;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ir = (q.size() < 2);
    ov = (q.size() > 0);
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      zero_exp = 1'b1;
    end else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && ir) begin
        q.push_back(d);
        zero_exp = 1'b0;
      end
    end
    #1;
    chk("in_ready",  W'(in_ready),  W'(q.size() < 2));
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("occupancy", W'(occupancy), W'(q.size()));
    if (q.size() > 0)  chk("out_data", out_data, q[0]);
    else if (zero_exp) chk("out_data_zero", out_data, '0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_data", out_data, 32'h0);

    // single entry, one-cycle latency
    step(0, 0, 1, 32'h0000_00A5, 1);
    chk("a5_data", out_data, 32'h0000_00A5);
    chk("a5_occ", W'(occupancy), W'(1));
    step(0, 0, 0, 0, 1);

    // back-to-back stream
    step(0, 0, 1, 32'h1, 1);
    chk("stream1", out_data, 32'h1);
    step(0, 0, 1, 32'h2, 1);
    chk("stream2", out_data, 32'h2);
    chk("stream_rdy", W'(in_ready), W'(1));
    step(0, 0, 1, 32'h3, 1);
    chk("stream3", out_data, 32'h3);
    step(0, 0, 0, 0, 1);

    // backpressure fills skid
    step(0, 0, 1, 32'h10, 0);
    step(0, 0, 1, 32'h20, 0);
    chk("full_occ", W'(occupancy), W'(2));
    chk("full_rdy", W'(in_ready), W'(0));
    chk("full_data", out_data, 32'h10);
    step(0, 0, 1, 32'h99, 0);
    chk("full_hold", out_data, 32'h10);
    step(0, 0, 0, 0, 1);
    chk("pop_20", out_data, 32'h20);
    chk("pop_rdy", W'(in_ready), W'(1));
    step(0, 0, 0, 0, 1);

    // flush while full with a competing input
    step(0, 0, 1, 32'h10, 0);
    step(0, 0, 1, 32'h20, 0);
    step(0, 1, 1, 32'h30, 1);
    chk("flush_occ", W'(occupancy), W'(0));
    chk("flush_data", out_data, 32'h0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // reset while full
    step(0, 0, 1, 32'h44, 0);
    step(0, 0, 1, 32'h55, 0);
    step(1, 0, 1, 32'h66, 1);
    chk("rst_full_valid", W'(out_valid), W'(0));
    chk("rst_full_rdy", W'(in_ready), W'(1));
    step(0, 0, 1, 32'h77, 1);
    chk("post_rst", out_data, 32'h77);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 511) == 0,
           $urandom_range(0, 127) == 0,
           $urandom_range(0, 3) != 0,
           $urandom,
           (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
